// File: rtl/core_pkg.sv
// Shared core definitions: decoded control bundle, ALUOp encodings, default width.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  // ALUOp encodings consumed by the ALU controller
  localparam logic [1:0] ALUOP_MEM = 2'b00;  // address add (loads/stores)
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_ALU = 2'b10;  // R/I-type, decode funct3/funct7
  localparam logic [1:0] ALUOP_JMP = 2'b11;  // jump link

  // Decoded control, MSB first in the listed order
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bundle: decoded fields in, registered EX view and hazard/debug status out.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  import core_pkg::*;

  // ID side and pipeline control
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  ctrl_t           id_ctrl;
  logic            flush;
  logic            ex_stall;

  // EX side and status
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [2:0]       ex_funct3;
  logic [6:0]       ex_funct7;
  ctrl_t            ex_ctrl;
  logic             stall_upstream;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_funct3, id_funct7, id_ctrl, flush, ex_stall,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_funct7, ex_ctrl, stall_upstream, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_funct3, id_funct7, id_ctrl, flush, ex_stall,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_funct7, ex_ctrl, stall_upstream, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard check between the load sitting in a later stage and the ID consumer.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic [4:0] id_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired zero, so a load targeting it never produces a dependency
  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold, and debug counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    ctrl_t           ctrl;
  } ex_reg_t;

  // An all-zero EX entry is invalid and has every side-effect control cleared
  localparam ex_reg_t BUBBLE = '0;

  ex_reg_t          ex_q;
  ex_reg_t          ex_d;
  logic             load_use;
  logic             flush_inc;
  logic             stall_inc;
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  hazard_detect u_hazard (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl.mem_read),
    .ex_rd       (ex_q.rd),
    .id_valid    (bus.id_valid),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_rs1      (bus.id_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .id_rs2      (bus.id_rs2),
    .load_use    (load_use)
  );

  // A flushed ID instruction is discarded anyway, so it must not also freeze the front end
  assign bus.stall_upstream = bus.ex_stall | (load_use & ~bus.flush);

  // Next EX contents: hold > flush bubble > load-use bubble > capture from ID
  always_comb begin
    ex_d      = ex_q;
    flush_inc = 1'b0;
    stall_inc = 1'b0;
    if (bus.ex_stall) begin
      ex_d = ex_q;
    end else if (bus.flush) begin
      ex_d      = BUBBLE;
      flush_inc = 1'b1;
    end else if (load_use) begin
      ex_d      = BUBBLE;
      stall_inc = 1'b1;
    end else begin
      ex_d.valid    = bus.id_valid;
      ex_d.pc       = bus.id_pc;
      ex_d.rs1_data = bus.id_rs1_data;
      ex_d.rs2_data = bus.id_rs2_data;
      ex_d.imm      = bus.id_imm;
      ex_d.rs1      = bus.id_rs1;
      ex_d.rs2      = bus.id_rs2;
      ex_d.rd       = bus.id_rd;
      ex_d.funct3   = bus.id_funct3;
      ex_d.funct7   = bus.id_funct7;
      ex_d.ctrl     = bus.id_ctrl;
    end
  end

  // EX pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Counter 0 tracks accepted flushes, counter 1 tracks load-use bubbles
  assign cnt_inc = {stall_inc, flush_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign bus.flush_cnt   = cnt_val[0];
  assign bus.stall_cnt   = cnt_val[1];

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_rs1_data = ex_q.rs1_data;
  assign bus.ex_rs2_data = ex_q.rs2_data;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_funct3   = ex_q.funct3;
  assign bus.ex_funct7   = ex_q.funct7;
  assign bus.ex_ctrl     = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX entries queued at drive time, popped after each edge.
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    ctrl_t           ctrl;
  } ex_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    ctrl_t           ctrl;
  } id_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(16)) dut_if ();
  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(2))  sat_if ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  // Second copy with 2-bit counters sees identical stimulus
  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sat_if.slave)
  );

  assign sat_if.id_valid    = dut_if.id_valid;
  assign sat_if.id_pc       = dut_if.id_pc;
  assign sat_if.id_rs1_data = dut_if.id_rs1_data;
  assign sat_if.id_rs2_data = dut_if.id_rs2_data;
  assign sat_if.id_imm      = dut_if.id_imm;
  assign sat_if.id_rs1      = dut_if.id_rs1;
  assign sat_if.id_rs2      = dut_if.id_rs2;
  assign sat_if.id_rd       = dut_if.id_rd;
  assign sat_if.id_uses_rs1 = dut_if.id_uses_rs1;
  assign sat_if.id_uses_rs2 = dut_if.id_uses_rs2;
  assign sat_if.id_funct3   = dut_if.id_funct3;
  assign sat_if.id_funct7   = dut_if.id_funct7;
  assign sat_if.id_ctrl     = dut_if.id_ctrl;
  assign sat_if.flush       = dut_if.flush;
  assign sat_if.ex_stall    = dut_if.ex_stall;

  ex_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_stall;
  logic [15:0] exp_flush;
  ctrl_t       c_lw, c_add, c_lui, c_sw, c_beq, c_none;

  function automatic ctrl_t mkc(input logic [1:0] op, input logic src, input logic mr,
                                input logic mw, input logic rw, input logic m2r,
                                input logic br, input logic jp);
    ctrl_t c;
    c.alu_op = op; c.alu_src = src; c.mem_read = mr; c.mem_write = mw;
    c.reg_write = rw; c.mem_to_reg = m2r; c.branch = br; c.jump = jp;
    return c;
  endfunction

  function automatic id_t mk_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic [2:0] f3, input logic [6:0] f7, input ctrl_t c);
    id_t s;
    s.valid = v; s.pc = $urandom; s.rs1_data = $urandom; s.rs2_data = $urandom;
    s.imm = $urandom; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.uses_rs1 = u1;
    s.uses_rs2 = u2; s.funct3 = f3; s.funct7 = f7; s.ctrl = c;
    return s;
  endfunction

  // What EX should show one cycle after a normal capture of s
  function automatic ex_t exp_of(input id_t s);
    ex_t e;
    e.valid = s.valid; e.pc = s.pc; e.rs1_data = s.rs1_data; e.rs2_data = s.rs2_data;
    e.imm = s.imm; e.rs1 = s.rs1; e.rs2 = s.rs2; e.rd = s.rd; e.funct3 = s.funct3;
    e.funct7 = s.funct7; e.ctrl = s.ctrl;
    return e;
  endfunction

  function automatic ex_t sample_ex();
    ex_t r;
    r.valid = dut_if.ex_valid; r.pc = dut_if.ex_pc; r.rs1_data = dut_if.ex_rs1_data;
    r.rs2_data = dut_if.ex_rs2_data; r.imm = dut_if.ex_imm; r.rs1 = dut_if.ex_rs1;
    r.rs2 = dut_if.ex_rs2; r.rd = dut_if.ex_rd; r.funct3 = dut_if.ex_funct3;
    r.funct7 = dut_if.ex_funct7; r.ctrl = dut_if.ex_ctrl;
    return r;
  endfunction

  task automatic drive(input id_t s, input logic fl, input logic st);
    dut_if.id_valid = s.valid; dut_if.id_pc = s.pc; dut_if.id_rs1_data = s.rs1_data;
    dut_if.id_rs2_data = s.rs2_data; dut_if.id_imm = s.imm; dut_if.id_rs1 = s.rs1;
    dut_if.id_rs2 = s.rs2; dut_if.id_rd = s.rd; dut_if.id_uses_rs1 = s.uses_rs1;
    dut_if.id_uses_rs2 = s.uses_rs2; dut_if.id_funct3 = s.funct3;
    dut_if.id_funct7 = s.funct7; dut_if.id_ctrl = s.ctrl;
    dut_if.flush = fl; dut_if.ex_stall = st;
    #1;
  endtask

  // Advance one edge and hand back the observed EX entry with its queued expectation
  task automatic clock_and_pop(output ex_t got, output ex_t exp);
    @(posedge clk);
    #1;
    got = sample_ex();
    if (sb.size() == 0) exp = ~got;
    else exp = sb.pop_front();
  endtask

  task automatic test_reset();
    ex_t got, exp;
    reset = 1'b1;
    drive(mk_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1,
                3'($urandom), 7'($urandom), c_lw), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('0);
      clock_and_pop(got, exp);
      n_checks++;
      if (got !== exp) begin $display("FAIL reset_ex got=%h exp=%h", got, exp); n_fail++; end
      n_checks++;
      if (dut_if.stall_cnt !== 16'd0 || dut_if.flush_cnt !== 16'd0 || sat_if.stall_cnt !== 2'd0) begin
        $display("FAIL reset_cnt stall=%0d flush=%0d sat=%0d exp=0", dut_if.stall_cnt,
                 dut_if.flush_cnt, sat_if.stall_cnt);
        n_fail++;
      end
    end
    n_checks++;
    if (dut_if.stall_upstream !== 1'b0) begin
      $display("FAIL reset_stall_up got=%b exp=0", dut_if.stall_upstream); n_fail++;
    end
    reset = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic test_passthrough();
    ex_t got, exp;
    id_t tbl[3];
    tbl[0] = mk_id(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 3'b000, 7'b0000000, c_add);
    tbl[1] = mk_id(1'b1, 5'd9, 5'd4, 5'd8, 1'b1, 1'b1, 3'b000, 7'b0100000, c_add);
    tbl[2] = mk_id(1'b1, 5'd0, 5'd10, 5'd11, 1'b1, 1'b1, 3'b001, 7'b0000000, c_beq);
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i], 1'b0, 1'b0);
      sb.push_back(exp_of(tbl[i]));
      clock_and_pop(got, exp);
      n_checks++;
      if (got !== exp) begin $display("FAIL pass_%0d got=%h exp=%h", i, got, exp); n_fail++; end
    end
  endtask

  task automatic test_load_use();
    ex_t got, exp;
    id_t lw, add;
    lw  = mk_id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    add = mk_id(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 3'b000, 7'd0, c_add);
    drive(lw, 1'b0, 1'b0);
    sb.push_back(exp_of(lw));
    clock_and_pop(got, exp);
    n_checks++;
    if (got !== exp) begin $display("FAIL lu_load got=%h exp=%h", got, exp); n_fail++; end
    drive(add, 1'b0, 1'b0);
    n_checks++;
    if (dut_if.stall_upstream !== 1'b1) begin
      $display("FAIL lu_stall_up got=%b exp=1", dut_if.stall_upstream); n_fail++;
    end
    sb.push_back('0);
    clock_and_pop(got, exp);
    exp_stall++;
    n_checks++;
    if (got !== exp) begin $display("FAIL lu_bubble got=%h exp=%h", got, exp); n_fail++; end
    n_checks++;
    if (dut_if.stall_cnt !== exp_stall || dut_if.flush_cnt !== exp_flush) begin
      $display("FAIL lu_cnt stall=%0d/%0d flush=%0d/%0d", dut_if.stall_cnt, exp_stall,
               dut_if.flush_cnt, exp_flush);
      n_fail++;
    end
    n_checks++;
    if (dut_if.stall_upstream !== 1'b0) begin
      $display("FAIL lu_release got=%b exp=0", dut_if.stall_upstream); n_fail++;
    end
    sb.push_back(exp_of(add));
    clock_and_pop(got, exp);
    n_checks++;
    if (got !== exp) begin $display("FAIL lu_advance got=%h exp=%h", got, exp); n_fail++; end
  endtask

  task automatic test_no_false_hazard();
    ex_t  got, exp;
    id_t  prod[5], cons[5];
    logic want[5];
    // producer / consumer pairs and whether the consumer must stall
    prod[0] = mk_id(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    cons[0] = mk_id(1'b1, 5'd7, 5'd0, 5'd2, 1'b1, 1'b1, 3'b000, 7'd0, c_add);  want[0] = 1'b0;
    prod[1] = mk_id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    cons[1] = mk_id(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 3'b000, 7'd0, c_lui);  want[1] = 1'b0;
    prod[2] = mk_id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    cons[2] = mk_id(1'b0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 3'b000, 7'd0, c_none); want[2] = 1'b0;
    prod[3] = mk_id(1'b0, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    cons[3] = mk_id(1'b1, 5'd8, 5'd5, 5'd2, 1'b1, 1'b1, 3'b000, 7'd0, c_add);  want[3] = 1'b0;
    prod[4] = mk_id(1'b1, 5'd12, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    cons[4] = mk_id(1'b1, 5'd0, 5'd3, 5'd12, 1'b1, 1'b1, 3'b010, 7'd0, c_sw);  want[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(prod[i], 1'b0, 1'b0);
      sb.push_back(exp_of(prod[i]));
      clock_and_pop(got, exp);
      n_checks++;
      if (got !== exp) begin $display("FAIL nf_prod_%0d got=%h exp=%h", i, got, exp); n_fail++; end
      drive(cons[i], 1'b0, 1'b0);
      n_checks++;
      if (dut_if.stall_upstream !== want[i]) begin
        $display("FAIL nf_stall_%0d got=%b exp=%b", i, dut_if.stall_upstream, want[i]); n_fail++;
      end
      if (want[i]) begin
        sb.push_back('0);
        clock_and_pop(got, exp);
        exp_stall++;
        n_checks++;
        if (got !== exp) begin $display("FAIL nf_bubble_%0d got=%h exp=%h", i, got, exp); n_fail++; end
      end
      sb.push_back(exp_of(cons[i]));
      clock_and_pop(got, exp);
      n_checks++;
      if (got !== exp) begin $display("FAIL nf_cons_%0d got=%h exp=%h", i, got, exp); n_fail++; end
    end
    n_checks++;
    if (dut_if.stall_cnt !== exp_stall) begin
      $display("FAIL nf_cnt got=%0d exp=%0d", dut_if.stall_cnt, exp_stall); n_fail++;
    end
  endtask

  task automatic test_flush();
    ex_t got, exp;
    id_t lw, add;
    lw  = mk_id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    add = mk_id(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 3'b000, 7'd0, c_add);
    // flush together with a load-use hazard
    drive(lw, 1'b0, 1'b0);
    sb.push_back(exp_of(lw));
    clock_and_pop(got, exp);
    n_checks++;
    if (got !== exp) begin $display("FAIL fl_load got=%h exp=%h", got, exp); n_fail++; end
    drive(add, 1'b1, 1'b0);
    n_checks++;
    if (dut_if.stall_upstream !== 1'b0) begin
      $display("FAIL fl_stall_up got=%b exp=0", dut_if.stall_upstream); n_fail++;
    end
    sb.push_back('0);
    clock_and_pop(got, exp);
    exp_flush++;
    n_checks++;
    if (got !== exp) begin $display("FAIL fl_bubble got=%h exp=%h", got, exp); n_fail++; end
    n_checks++;
    if (dut_if.stall_cnt !== exp_stall || dut_if.flush_cnt !== exp_flush) begin
      $display("FAIL fl_cnt stall=%0d/%0d flush=%0d/%0d", dut_if.stall_cnt, exp_stall,
               dut_if.flush_cnt, exp_flush);
      n_fail++;
    end
    // flush while the downstream hold is asserted: nothing moves
    drive(lw, 1'b0, 1'b0);
    sb.push_back(exp_of(lw));
    clock_and_pop(got, exp);
    n_checks++;
    if (got !== exp) begin $display("FAIL fh_load got=%h exp=%h", got, exp); n_fail++; end
    drive(add, 1'b1, 1'b1);
    n_checks++;
    if (dut_if.stall_upstream !== 1'b1) begin
      $display("FAIL fh_stall_up got=%b exp=1", dut_if.stall_upstream); n_fail++;
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exp_of(lw));
      clock_and_pop(got, exp);
      n_checks++;
      if (got !== exp) begin $display("FAIL fh_hold_%0d got=%h exp=%h", i, got, exp); n_fail++; end
    end
    n_checks++;
    if (dut_if.stall_cnt !== exp_stall || dut_if.flush_cnt !== exp_flush) begin
      $display("FAIL fh_cnt stall=%0d/%0d flush=%0d/%0d", dut_if.stall_cnt, exp_stall,
               dut_if.flush_cnt, exp_flush);
      n_fail++;
    end
    // hold released, flush re-asserted by its source
    drive(add, 1'b1, 1'b0);
    sb.push_back('0);
    clock_and_pop(got, exp);
    exp_flush++;
    n_checks++;
    if (got !== exp || dut_if.flush_cnt !== exp_flush) begin
      $display("FAIL fh_release got=%h exp=%h flush=%0d/%0d", got, exp, dut_if.flush_cnt, exp_flush);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    ex_t   got, exp;
    id_t   s;
    ctrl_t c;
    for (int i = 0; i < 8; i++) begin
      c = 9'($urandom);
      c.mem_read = 1'b0;
      s = mk_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                1'($urandom), 3'($urandom), 7'($urandom), c);
      drive(s, 1'b0, 1'b0);
      sb.push_back(exp_of(s));
      clock_and_pop(got, exp);
      n_checks++;
      if (got !== exp) begin $display("FAIL b2b_%0d got=%h exp=%h", i, got, exp); n_fail++; end
    end
  endtask

  task automatic test_mid_stall_reset();
    ex_t got, exp;
    id_t lw, add;
    lw  = mk_id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    add = mk_id(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 3'b000, 7'd0, c_add);
    drive(lw, 1'b0, 1'b0);
    sb.push_back(exp_of(lw));
    clock_and_pop(got, exp);
    n_checks++;
    if (got !== exp) begin $display("FAIL rs_load got=%h exp=%h", got, exp); n_fail++; end
    drive(add, 1'b0, 1'b0);
    reset = 1'b1;
    sb.push_back('0);
    clock_and_pop(got, exp);
    exp_stall = '0;
    exp_flush = '0;
    n_checks++;
    if (got !== exp || dut_if.stall_upstream !== 1'b0) begin
      $display("FAIL rs_clear got=%h exp=%h stall_up=%b exp=0", got, exp, dut_if.stall_upstream);
      n_fail++;
    end
    n_checks++;
    if (dut_if.stall_cnt !== exp_stall || dut_if.flush_cnt !== exp_flush) begin
      $display("FAIL rs_cnt stall=%0d flush=%0d exp=0", dut_if.stall_cnt, dut_if.flush_cnt); n_fail++;
    end
    dut_if.ex_stall = 1'b1;
    #1;
    n_checks++;
    if (dut_if.stall_upstream !== 1'b1) begin
      $display("FAIL rs_hold_up got=%b exp=1", dut_if.stall_upstream); n_fail++;
    end
    dut_if.ex_stall = 1'b0;
    reset = 1'b0;
    #1;
    sb.push_back(exp_of(add));
    clock_and_pop(got, exp);
    n_checks++;
    if (got !== exp) begin $display("FAIL rs_advance got=%h exp=%h", got, exp); n_fail++; end
  endtask

  task automatic test_saturation();
    ex_t        got, exp;
    id_t        lw, use5;
    logic [1:0] exp_sat;
    lw   = mk_id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 3'b010, 7'd0, c_lw);
    use5 = mk_id(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 3'b000, 7'd0, c_add);
    reset = 1'b1;
    drive(lw, 1'b0, 1'b0);
    sb.push_back('0);
    clock_and_pop(got, exp);
    reset = 1'b0;
    exp_stall = '0;
    exp_sat   = '0;
    n_checks++;
    if (got !== exp) begin $display("FAIL sat_reset got=%h exp=%h", got, exp); n_fail++; end
    for (int k = 1; k <= 5; k++) begin
      drive(lw, 1'b0, 1'b0);
      sb.push_back(exp_of(lw));
      clock_and_pop(got, exp);
      n_checks++;
      if (got !== exp) begin $display("FAIL sat_load_%0d got=%h exp=%h", k, got, exp); n_fail++; end
      drive(use5, 1'b0, 1'b0);
      sb.push_back('0);
      clock_and_pop(got, exp);
      exp_stall++;
      if (exp_sat != 2'd3) exp_sat = exp_sat + 2'd1;
      n_checks++;
      if (sat_if.stall_cnt !== exp_sat || dut_if.stall_cnt !== exp_stall) begin
        $display("FAIL sat_cnt_%0d sat=%0d/%0d wide=%0d/%0d", k, sat_if.stall_cnt, exp_sat,
                 dut_if.stall_cnt, exp_stall);
        n_fail++;
      end
    end
    sb.push_back(exp_of(use5));
    clock_and_pop(got, exp);
    n_checks++;
    if (got !== exp || sat_if.stall_cnt !== 2'd3) begin
      $display("FAIL sat_final got=%h exp=%h sat=%0d exp=3", got, exp, sat_if.stall_cnt); n_fail++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    c_lw   = mkc(ALUOP_MEM, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    c_add  = mkc(ALUOP_ALU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    c_lui  = mkc(ALUOP_ALU, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    c_sw   = mkc(ALUOP_MEM, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    c_beq  = mkc(ALUOP_BR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    c_none = '0;
    exp_stall = '0;
    exp_flush = '0;
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_back_to_back();
    test_mid_stall_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core.
- Captures decoded fields from the decoder and register file, and presents them to EX: ALUOp/Funct3/Funct7 to the ALU controller, operands to the ALU.
- Detects load-use hazards and inserts bubbles.
- Applies branch flushes and downstream holds, and keeps saturating stall/flush counters for debug.

Parameters:
XLEN, 32, datapath width (pc, operands, immediate)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears every register
id_valid  input  1  ID holds a real instruction
id_pc  input  XLEN  instruction PC
id_rs1_data  input  XLEN  register-file read data 1
id_rs2_data  input  XLEN  register-file read data 2
id_imm  input  XLEN  sign-extended immediate
id_rs1  input  5  source register 1 index
id_rs2  input  5  source register 2 index
id_rd  input  5  destination register index
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_funct3  input  3  instruction bits 14:12
id_funct7  input  7  instruction bits 31:25
id_ctrl  input  ctrl_t(9)  alu_op[1:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump
flush  input  1  branch/jump redirect resolved in EX; kill the instruction entering EX
ex_stall  input  1  downstream hold (memory not ready)
ex_valid  output  1  EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered copies
ex_rs1, ex_rs2, ex_rd  output  5 each  registered indices (for forwarding unit)
ex_funct3  output  3  to ALU controller
ex_funct7  output  7  to ALU controller
ex_ctrl  output  ctrl_t(9)  registered control; ex_ctrl.alu_op feeds the ALU controller ALUOp
stall_upstream  output  1  combinational; hold PC and IF/ID this cycle
stall_cnt  output  CNT_W  load-use bubbles inserted, saturating
flush_cnt  output  CNT_W  flushes accepted, saturating

Behaviour:
- Reset (synchronous, highest priority):
  - All outputs and registers become 0, so ex_valid=0 and ex_ctrl=0 (alu_op=00, i.e. add, no side effects).
  - Counters become 0.
- Load-use hazard (combinational):
  - load_use = ex_valid & ex_ctrl.mem_read & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Upstream hold:
  - stall_upstream = ex_stall | (load_use & ~flush).
  - Flush overrides load_use because the ID instruction is being killed.
- Per-cycle update, priority order:
  1. reset.
  2. ex_stall=1: hold every EX register unchanged. flush and load_use are ignored; the flush source re-asserts while its instruction is held.
  3. flush=1: load a bubble; flush_cnt+1.
  4. load_use=1: load a bubble; stall_cnt+1.
  5. Otherwise load all id_* fields, with ex_valid<=id_valid.
- Bubble definition:
  - ex_valid=0, ex_ctrl=0, all datapath/index/funct fields 0.
  - A bubble can never write the register file or memory.
- Latency:
  - One cycle from ID capture to EX presentation.
  - A load-use stall costs exactly one bubble: the next cycle ex_mem_read of the bubble is 0, so load_use deasserts and the ID instruction advances.
- id_valid=0 with no stall loads a bubble-equivalent. Control fields are loaded as given; downstream units qualify with ex_valid. The decoder guarantees ex_ctrl=0 when id_valid=0.
- rd=x0 never triggers load_use.
- Counters saturate at all-ones and do not wrap. Increments happen only on the accepted event, never while ex_stall=1.
- Reset asserted mid-stall clears state immediately. stall_upstream is then 0 because ex_valid=0, unless ex_stall is still high.

Decomposition:
- Package core_pkg: ctrl_t packed struct (field order as listed), ALUOP_MEM=2'b00, ALUOP_BR=2'b01, ALUOP_ALU=2'b10, ALUOP_JMP=2'b11, XLEN default.
- Sub-module hazard_detect: purely combinational load_use. It is reused later by the EX/MEM stage.
- Counters are a small sat_counter instance (CNT_W, inc, reset) used twice.

Test Plan:
- Reset: assert reset 2 cycles with id_valid=1 and random fields -> ex_valid=0, ex_ctrl=0, stall_cnt=flush_cnt=0.
- Pass-through: id add x3,x1,x2 (funct7=0000000, funct3=000, alu_op=10, reg_write=1) -> next cycle ex_funct7=0, ex_funct3=0, ex_ctrl.alu_op=10, ex_valid=1, ex_rd=3.
- Load-use:
  - Stimulus: EX holds lw x5 (mem_read=1, rd=5); ID holds add x6,x5,x7 with uses_rs1=1.
  - Response: stall_upstream=1. The next EX is a bubble (ex_valid=0), stall_cnt=1. The following cycle loads the add, with stall_upstream=0.
- No false hazard:
  - lw x0 followed by a rs1=0 user -> no stall.
  - lw x5 followed by lui x5 (uses_rs1=uses_rs2=0) -> no stall.
- Flush vs stall:
  - flush=1 with load_use=1 -> bubble, flush_cnt+1, stall_cnt unchanged, stall_upstream=0.
  - flush=1 with ex_stall=1 -> EX registers held, flush_cnt unchanged, stall_upstream=1.
- Saturation: CNT_W=2, force 5 load-use events -> stall_cnt reads 3 and stays at 3.
